// File: rtl/rv32i_types.sv
// Shared type and constant package for the L1 cache subsystem.
// Holds the cacheline_adapter state encoding and the line/beat geometry
// used between the cache (256-bit line port) and banked memory (64-bit beats).
package rv32i_types;

    // States of the cache-line <-> memory-burst adapter.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        RESP    = 3'd4
    } cla_state_t;

    localparam int CACHE_LINE_W = 256;
    localparam int BMEM_BEAT_W  = 64;
    localparam int BMEM_BEATS   = CACHE_LINE_W / BMEM_BEAT_W;

endpackage : rv32i_types

// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//   Converts single-transfer cache-line reads/writes from the L1 cache (dfp
//   port) into 4-beat bursts on the banked memory port (bmem). Read beats are
//   assembled into one line; write lines are split into beats. Each request
//   completes with a one-cycle dfp_resp pulse. All outputs are registered.
//
// Optional feature (macro CACHELINE_ADAPTER_RADDR_CHECK_EN):
//   When defined, read beats whose bmem_raddr does not match the latched line
//   address are dropped and raise the sticky raddr_err flag. When undefined,
//   bmem_raddr is unused and raddr_err is tied low.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   dfp_addr/read/write/wdata cache-side line request (held until dfp_resp)
//   dfp_rdata, dfp_resp       assembled read line, completion pulse
//   bmem_addr/read/write/wdata  burst command / write beat to memory
//   bmem_ready                memory accepts command or write beat
//   bmem_raddr/rdata/rvalid   returning read beat
//   raddr_err                 sticky read-address mismatch flag
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int LINE_W = CACHE_LINE_W,
    parameter int BEAT_W = BMEM_BEAT_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              raddr_err
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFFS  = $clog2(LINE_W / 8);

    cla_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              resp_q, resp_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [BEAT_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] aligned_addr_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              cnt_last_s;
    logic              beat_take_s;
    logic              beat_bad_s;
    logic              unused_s;

    // Byte offset within the line is meaningless to memory; force it to zero.
    assign aligned_addr_s = {dfp_addr[ADDR_W-1:OFFS], {OFFS{1'b0}}};
    assign cnt_inc_s      = cnt_q + CNT_W'(1);
    assign cnt_last_s     = (cnt_q == CNT_W'(BEATS - 1));

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    // Only beats tagged with our own line address count toward the line.
    assign beat_bad_s  = bmem_rvalid && (bmem_raddr != addr_q);
    assign beat_take_s = bmem_rvalid && !beat_bad_s;
    assign unused_s    = ^dfp_addr[OFFS-1:0];
`else
    assign beat_bad_s  = 1'b0;
    assign beat_take_s = bmem_rvalid;
    assign unused_s    = ^{dfp_addr[OFFS-1:0], bmem_raddr, beat_bad_s, err_q};
`endif

    // State and datapath registers; reset returns to IDLE and drops any partial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; a write wins when both requests arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dfp_write) begin
                    state_d = WR_DATA;
                end else if (dfp_read) begin
                    state_d = RD_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_DATA: begin
                if (beat_take_s && cnt_last_s) begin
                    state_d = RESP;
                end else begin
                    state_d = RD_DATA;
                end
            end
            WR_DATA: begin
                if (bmem_ready && cnt_last_s) begin
                    state_d = RESP;
                end else begin
                    state_d = WR_DATA;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath for the coming cycle.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        resp_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (dfp_write) begin
                    addr_d  = aligned_addr_s;
                    line_d  = dfp_wdata;
                    wr_d    = 1'b1;
                    wdata_d = dfp_wdata[BEAT_W-1:0];
                    cnt_d   = '0;
                end else if (dfp_read) begin
                    addr_d = aligned_addr_s;
                    rd_d   = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            RD_REQ: begin
                // Command stays up until memory samples it.
                if (bmem_ready) begin
                    rd_d  = 1'b0;
                    cnt_d = '0;
                end else begin
                    rd_d = 1'b1;
                end
            end
            RD_DATA: begin
                if (beat_take_s) begin
                    rdata_d[int'(cnt_q)*BEAT_W +: BEAT_W] = bmem_rdata;
                    cnt_d  = cnt_inc_s;
                    resp_d = cnt_last_s;
                end else begin
                    cnt_d = cnt_q;
                end
                if (beat_bad_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            WR_DATA: begin
                // Without an accept the current beat is presented again unchanged.
                if (bmem_ready) begin
                    if (cnt_last_s) begin
                        wr_d   = 1'b0;
                        resp_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        wr_d    = 1'b1;
                        cnt_d   = cnt_inc_s;
                        wdata_d = line_q[int'(cnt_inc_s)*BEAT_W +: BEAT_W];
                    end
                end else begin
                    wr_d = 1'b1;
                end
            end
            RESP: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign dfp_rdata  = rdata_q;
    assign dfp_resp   = resp_q;
    assign bmem_addr  = addr_q;
    assign bmem_read  = rd_q;
    assign bmem_write = wr_q;
    assign bmem_wdata = wdata_q;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    assign raddr_err = err_q;
`else
    assign raddr_err = 1'b0;
`endif

endmodule : cacheline_adapter

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter. Memory is modelled behaviourally:
// expected read lines are the beats the bench sends, concatenated low beat
// first; expected write beats are slices of the line the bench offers.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         raddr_err;

    int errors = 0;
    int checks = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .raddr_err(raddr_err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Issue a line read; memory answers after rdy_delay cycles, beats separated by gap idle cycles.
    // bad_at >= 0 injects one wrongly tagged beat before that beat index.
    task automatic do_read(input logic [31:0] addr, input int rdy_delay, input int gap,
                           input logic [255:0] line, input int bad_at);
        int rd_cycles;
        int early_resp;
        @(negedge clk);
        dfp_addr = addr; dfp_read = 1'b1; dfp_write = 1'b0; bmem_ready = 1'b0;
        @(negedge clk);
        check("rd_cmd_lat", 256'(bmem_read), 256'(1'b1));
        check("rd_addr", 256'(bmem_addr), 256'(line_base(addr)));
        rd_cycles = bmem_read ? 1 : 0;
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            rd_cycles += bmem_read ? 1 : 0;
        end
        bmem_ready = 1'b1;
        @(negedge clk);
        bmem_ready = 1'b0;
        check("rd_hold", 256'(rd_cycles), 256'(rdy_delay + 1));
        check("rd_cmd_drop", 256'(bmem_read), 256'(1'b0));
        early_resp = 0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                bmem_rvalid = 1'b0;
                @(negedge clk);
                early_resp += dfp_resp ? 1 : 0;
            end
            if (b == bad_at) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = line_base(addr) ^ 32'h0000_0040;
                bmem_rdata  = {$urandom, $urandom};
                exp_err     = 1'b1;
                @(negedge clk);
                early_resp += dfp_resp ? 1 : 0;
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = line_base(addr);
            bmem_rdata  = line[b*64 +: 64];
            @(negedge clk);
            if (b < 3) early_resp += dfp_resp ? 1 : 0;
        end
        bmem_rvalid = 1'b0;
        check("rd_resp_early", 256'(early_resp), 256'(0));
        check("rd_resp_lat", 256'(dfp_resp), 256'(1'b1));
        check("rd_line", dfp_rdata, line);
        dfp_read = 1'b0;
        @(negedge clk);
        check("rd_resp_pulse", 256'(dfp_resp), 256'(1'b0));
        check("rd_line_hold", dfp_rdata, line);
        check("rd_raddr_err", 256'(raddr_err), 256'(exp_err));
    endtask

    // Issue a line write; pat_len>0 takes ready from pat bit by bit, otherwise random ready.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input logic also_read,
                            input logic [15:0] pat, input int pat_len);
        int acc;
        int idx;
        int rd_seen;
        int early_resp;
        logic r;
        @(negedge clk);
        dfp_addr = addr; dfp_write = 1'b1; dfp_read = also_read; dfp_wdata = line; bmem_ready = 1'b0;
        @(negedge clk);
        check("wr_cmd_lat", 256'(bmem_write), 256'(1'b1));
        acc = 0; idx = 0; rd_seen = 0; early_resp = 0;
        while (acc < 4 && idx < 60) begin
            rd_seen    += bmem_read ? 1 : 0;
            early_resp += dfp_resp ? 1 : 0;
            check("wr_valid", 256'(bmem_write), 256'(1'b1));
            check("wr_addr", 256'(bmem_addr), 256'(line_base(addr)));
            check("wr_beat", 256'(bmem_wdata), 256'(line[acc*64 +: 64]));
            r = (pat_len > 0) ? pat[idx % 16] : 1'($urandom_range(0, 1));
            idx++;
            bmem_ready = r;
            if (r) acc++;
            @(negedge clk);
        end
        bmem_ready = 1'b0;
        if (acc < 4) check("wr_timeout", 256'(acc), 256'(4));
        rd_seen += bmem_read ? 1 : 0;
        check("wr_done", 256'(bmem_write), 256'(1'b0));
        check("wr_resp_lat", 256'(dfp_resp), 256'(1'b1));
        check("wr_resp_early", 256'(early_resp), 256'(0));
        check("wr_no_read", 256'(rd_seen), 256'(0));
        dfp_write = 1'b0; dfp_read = 1'b0;
        @(negedge clk);
        check("wr_resp_pulse", 256'(dfp_resp), 256'(1'b0));
        check("wr_idle_read", 256'(bmem_read), 256'(1'b0));
    endtask

    logic [255:0] seq_line;
    logic [255:0] wr_line;
    int stray;

    initial begin
        seq_line = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
        wr_line  = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
        rst = 1'b0; dfp_addr = 32'h0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = 32'h0; bmem_rdata = 64'h0; bmem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_resp", 256'(dfp_resp), 256'(1'b0));
        check("rst_read", 256'(bmem_read), 256'(1'b0));
        check("rst_write", 256'(bmem_write), 256'(1'b0));
        check("rst_addr", 256'(bmem_addr), 256'(0));
        check("rst_wdata", 256'(bmem_wdata), 256'(0));
        check("rst_rdata", dfp_rdata, 256'(0));
        check("rst_err", 256'(raddr_err), 256'(1'b0));
        rst = 1'b1;

        // Back-to-back read, then stalled read of the same line.
        do_read(32'h0000_1234, 0, 0, seq_line, -1);
        do_read(32'h0000_1234, 3, 2, seq_line, -1);

        // Write with ready 1,0,1,0,1,1.
        do_write(32'h0000_2468, wr_line, 1'b0, 16'b0000_0000_0011_0101, 6);

        // Read and write together: write wins.
        do_write($urandom, rand_line(), 1'b1, 16'h0, 0);

        // Reset after two beats of a read.
        @(negedge clk);
        dfp_addr = 32'h0000_5A5F; dfp_read = 1'b1; bmem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bmem_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_5A40; bmem_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        bmem_rvalid = 1'b0; dfp_read = 1'b0;
        rst = 1'b0;
        exp_err = 1'b0;
        #1;
        check("mid_rst_read", 256'(bmem_read), 256'(1'b0));
        check("mid_rst_addr", 256'(bmem_addr), 256'(0));
        check("mid_rst_rdata", dfp_rdata, 256'(0));
        check("mid_rst_resp", 256'(dfp_resp), 256'(1'b0));
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            stray += (dfp_resp || bmem_read || bmem_write) ? 1 : 0;
        end
        bmem_rvalid = 1'b0;
        check("stray_ignored", 256'(stray), 256'(0));
        check("stray_rdata", dfp_rdata, 256'(0));
        do_read(32'h0000_5A5F, 1, 0, seq_line ^ 256'hF0F0, -1);

        // Randomized mix.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 0)
                do_read($urandom, $urandom_range(0, 4), $urandom_range(0, 3), rand_line(), -1);
            else
                do_write($urandom, rand_line(), 1'($urandom_range(0, 1)), 16'h0, 0);
        end

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
        // Mismatched beat tag: dropped, sticky error, line still completes.
        do_read(32'h0000_9870, 0, 1, rand_line(), 1);
        do_read(32'h0000_9900, 0, 0, rand_line(), -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cacheline_adapter

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Downstream neighbour of the L1 cache. Converts the cache's single-transfer 256-bit line read/write (dfp port) into 4-beat 64-bit bursts on the banked memory port (bmem).
- Deserialises read bursts into one line, serialises write lines into beats, and returns a one-cycle dfp_resp per request.
- One instance per cache, between the cache and the memory arbiter/model.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory beat width in bits; derived localparam BEATS = LINE_W/BEAT_W (4).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- dfp_addr  in  ADDR_W  line address from cache.
- dfp_read  in  1  line read request, held until dfp_resp.
- dfp_write  in  1  line write request, held until dfp_resp.
- dfp_wdata  in  LINE_W  line to write.
- dfp_rdata  out  LINE_W  assembled read line.
- dfp_resp  out  1  request complete, one-cycle pulse.
- bmem_addr  out  ADDR_W  burst base address, line-aligned.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  burst write beat valid.
- bmem_wdata  out  BEAT_W  write beat data.
- bmem_ready  in  1  memory accepts command/beat this cycle.
- bmem_raddr  in  ADDR_W  address tag of returning read beat.
- bmem_rdata  in  BEAT_W  read beat data.
- bmem_rvalid  in  1  read beat valid.
- raddr_err  out  1  sticky mismatch flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low.
- Reset values: state IDLE, beat counter 0, dfp_resp 0, bmem_read 0, bmem_write 0, bmem_addr 0, bmem_wdata 0, dfp_rdata 0, raddr_err 0. All outputs are registered.
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
- IDLE:
  - dfp_write -> latch {dfp_addr[31:5],5'b0} and dfp_wdata, go to WR_DATA.
  - Else dfp_read -> latch the aligned address, go to RD_REQ.
  - If both are high, write wins.
  - bmem_rvalid is ignored in IDLE.
- RD_REQ: bmem_read=1 and bmem_addr=the latched address, held until bmem_ready=1. On the cycle bmem_ready is sampled high, deassert bmem_read next cycle and go to RD_DATA with counter=0.
- RD_DATA:
  - Each cycle with bmem_rvalid=1 writes dfp_rdata[cnt*64 +: 64]=bmem_rdata and increments cnt.
  - Gaps (rvalid=0) are allowed and stall the counter.
  - On beat 3 the 2-bit counter wraps to 0 and the state goes to RESP.
- WR_DATA:
  - bmem_write=1, bmem_addr=the latched address for all beats, bmem_wdata=line[cnt*64 +: 64].
  - A beat is accepted when bmem_ready=1 and cnt increments.
  - If bmem_ready is low, bmem_write and bmem_wdata are held stable.
  - On the 4th accepted beat, deassert bmem_write next cycle and go to RESP.
- RESP: dfp_resp=1 for exactly one cycle, then IDLE.
- dfp_rdata holds the assembled line from the RESP cycle until the first beat of the next read.
- Latency:
  - Read: dfp_resp is asserted 1 cycle after the cycle the 4th rvalid beat is captured.
  - Write: dfp_resp is asserted 1 cycle after the 4th bmem_ready accept.
  - Minimum read: request seen in IDLE -> bmem_read next cycle.
- Requests are not pipelined: dfp_read/dfp_write are not sampled outside IDLE. In the cycle after RESP the cache has dropped its request, so no re-trigger occurs.
- Reset mid-burst: immediate return to IDLE, counter 0, partial line discarded. Beats still arriving from memory are ignored in IDLE.
- Address low bits dfp_addr[4:0] are ignored, forced to 0.

Optional Feature:
- Macro: CACHELINE_ADAPTER_RADDR_CHECK_EN.
- Defined: in RD_DATA, a beat whose bmem_raddr != the latched line address is dropped (not stored, counter not advanced) and sets raddr_err=1 sticky until reset.
- Undefined: bmem_raddr is unused, every rvalid beat is counted, and raddr_err is tied 0.

Decomposition:
- Shared package rv32i_types gains:
  - Enum typedef cla_state_t {IDLE, RD_REQ, RD_DATA, WR_DATA, RESP}.
  - Constants CACHE_LINE_W=256, BMEM_BEAT_W=64, BMEM_BEATS=4.
- No sub-module. The beat mux and demux are small enough to be inline indexed part-selects.

Test Plan:
- Read, no gaps:
  - Stimulus: dfp_read, addr 0x0000_1234; ready on first request cycle; beats 0x11..,0x22..,0x33..,0x44.. back-to-back.
  - Response: bmem_addr=0x0000_1220; dfp_rdata={0x44..,0x33..,0x22..,0x11..}; single dfp_resp the cycle after beat 4.
- Read with stalls: ready delayed 3 cycles, rvalid gaps of 2 cycles between beats -> bmem_read held 4 cycles; line identical to the no-gap case; one dfp_resp.
- Write with backpressure:
  - Stimulus: line 0xDDDD..CCCC..BBBB..AAAA; ready toggling 1,0,1,0,1,1.
  - Response: beats AAAA,BBBB,CCCC,DDDD in order; bmem_wdata held during ready=0; dfp_resp after the 4th accept.
- Simultaneous dfp_read and dfp_write in IDLE -> write burst issued, bmem_read never asserted.
- Reset mid-burst: rst low after beat 2 of a read -> all outputs at reset values; subsequent stray rvalid ignored; a new read completes correctly.
- Address mismatch: with CACHELINE_ADAPTER_RADDR_CHECK_EN defined, a beat with a wrong bmem_raddr -> beat dropped, raddr_err=1, and the line completes after 4 matching beats.
